// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings,
// PC source codes and the instruction fields the sequencer inspects.
package multicycle_sequencer_pkg;

    // Sequencer states; the numeric values are visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    // PC next-value selection.
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    // Opcode shared by loads, stores and memory-indirect jumps.
    localparam logic [3:0] OP_MEM = 4'b0100;

    // Instruction bit positions: mem_jmp marks the jump form of OP_MEM,
    // st_ld picks store (1) or load (0).
    localparam int unsigned MEM_JMP_BIT = 7;
    localparam int unsigned ST_LD_BIT   = 6;

    // True when the instruction needs a data-memory access.
    function automatic logic is_mem_op(input logic [15:0] ir);
        return (ir[15:12] == OP_MEM) && !ir[MEM_JMP_BIT];
    endfunction

    // True when a memory instruction is a store.
    function automatic logic is_store(input logic [15:0] ir);
        return ir[ST_LD_BIT];
    endfunction

endpackage

// File: rtl/multicycle_sequencer_seq_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ready and flags a
// timeout once the count reaches WAIT_LIMIT with the memory still not ready.
module seq_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    logic [7:0] cnt_q;

    // Wait counter: cleared on state transitions, counts stalled cycles and
    // never runs past the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !ready && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // A ready in the limit cycle wins over the timeout.
    assign timeout = enable && !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit processor.
// Owns the control FSM, strobe decode, retire counter and sticky fault flag.
//
// Memory handshake: mem_req is held high for the whole FETCH or MEM state;
// the memory completes the request in the first cycle it drives mem_ready
// high while mem_req is high, and the sequencer leaves the state on that
// edge. mem_we is meaningful only while mem_req is high. If mem_ready has
// not arrived by the WAIT_LIMIT-th stalled cycle the sequencer parks in FAULT.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned RET_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [15:0]      instr,
    input  logic             ctl_rwren,
    input  logic             ctl_dwren,
    input  logic             ctl_jmp,
    input  logic             ctl_branch,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             busy,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    logic             fault_q;
    logic [RET_W-1:0] retired_q;

    logic             mem_op;
    logic             store_op;
    logic             in_mem_phase;
    logic             wait_clear;
    logic             timeout;

    assign mem_op       = is_mem_op(instr);
    assign store_op     = is_store(instr);
    assign in_mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Every state change restarts the wait count, which covers entry into
    // FETCH and MEM (including the direct MEM -> FETCH store path).
    assign wait_clear   = (state_d != state_q);

    seq_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .enable  (in_mem_phase),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; write enables from the decoder are only
    // passed through in MEM (mem_we) and WB (rf_we).
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_INC;
        rf_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end

            // Decoder settles on the freshly loaded IR.
            ST_DECODE: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = mem_op ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = ctl_dwren;
                if (mem_ready) begin
                    if (store_op) begin
                        // Stores have nothing to write back: retire here.
                        pc_en   = 1'b1;
                        pc_src  = PC_INC;
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end

            ST_WB: begin
                rf_we = ctl_rwren;
                pc_en = 1'b1;
                if (ctl_jmp) begin
                    pc_src = PC_JMP;
                end else if (ctl_branch) begin
                    pc_src = PC_BR;
                end else begin
                    pc_src = PC_INC;
                end
                state_d = run ? ST_FETCH : ST_IDLE;
            end

            // Parked until reset; run is ignored.
            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky fault flag, raised on the edge that enters FAULT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (state_d == ST_FAULT) begin
            fault_q <= 1'b1;
        end
    end

    // Retired-instruction counter: one per PC update, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (pc_en) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign state   = state_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each scenario queues per-cycle stimulus and
// the expected output vector, then replays the stimulus and checks every cycle.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam int unsigned WAIT_LIMIT = 3;
    localparam int unsigned RET_W      = 4;
    localparam int OW = 13;
    localparam int SW = 7;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic [15:0]      instr = '0;
    logic             ctl_rwren = 1'b0;
    logic             ctl_dwren = 1'b0;
    logic             ctl_jmp = 1'b0;
    logic             ctl_branch = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_load;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             rf_we;
    logic [2:0]       state;
    logic             busy;
    logic             fault;
    logic [RET_W-1:0] retired;

    multicycle_sequencer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .RET_W      (RET_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .instr        (instr),
        .ctl_rwren    (ctl_rwren),
        .ctl_dwren    (ctl_dwren),
        .ctl_jmp      (ctl_jmp),
        .ctl_branch   (ctl_branch),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_en        (pc_en),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .state        (state),
        .busy         (busy),
        .fault        (fault),
        .retired      (retired)
    );

    // scoreboard state
    logic [OW-1:0]    exp_q[$];
    logic [SW-1:0]    stim_q[$];
    logic [SW-1:0]    cur_stim;
    logic [RET_W-1:0] exp_ret = '0;
    int               n_checks = 0;
    int               n_errors = 0;
    logic             c_rw, c_dw, c_j, c_b;

    // Expected output vector {state, req, we, sel, irl, pce, src, rfwe, busy, fault}.
    function automatic logic [OW-1:0] ev(input logic [2:0] st, input logic req, input logic we,
                                         input logic sel, input logic irl, input logic pce,
                                         input logic [1:0] src, input logic rfwe);
        logic bsy, flt;
        bsy = (st != 3'd0) && (st != 3'd6);
        flt = (st == 3'd6);
        return {st, req, we, sel, irl, pce, src, rfwe, bsy, flt};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {state, mem_req, mem_we, mem_addr_sel, ir_load, pc_en, pc_src, rf_we, busy, fault};
    endfunction

    // Stimulus vector {rst_n, run, mem_ready, rwren, dwren, jmp, branch}.
    function automatic logic [SW-1:0] st(input logic r, input logic rdy);
        return {1'b1, r, rdy, c_rw, c_dw, c_j, c_b};
    endfunction

    function automatic logic [SW-1:0] st_rst();
        return {1'b0, 1'b0, 1'b0, c_rw, c_dw, c_j, c_b};
    endfunction

    // driver tasks
    task automatic push(input logic [SW-1:0] s, input logic [OW-1:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [SW-1:0] s);
        @(posedge clk);
        #1;
        cur_stim = s;
        {rst_n, run, mem_ready, ctl_rwren, ctl_dwren, ctl_jmp, ctl_branch} = s;
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic [15:0] ir, input logic rw, input logic dw,
                           input logic j, input logic b);
        instr = ir;
        c_rw = rw;
        c_dw = dw;
        c_j  = j;
        c_b  = b;
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(st_rst(), ev(ST_IDLE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 0), ev(ST_IDLE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_IDLE, 0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL reset cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL reset cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // Two immediate ALU instructions back to back, then stop.
    task automatic test_alu();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h5123, 1'b1, 1'b0, 1'b0, 1'b0);
        push(st(1, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_WB,     0, 0, 0, 0, 1, PC_INC, 1));
        push(st(0, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_WB,     0, 0, 0, 0, 1, PC_INC, 1));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL alu cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL alu cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // Load with three stalled MEM cycles; ready lands exactly at the limit.
    task automatic test_load();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h4203, 1'b1, 1'b0, 1'b0, 1'b0);
        push(st(1, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        for (int i = 0; i < 3; i++) begin
            push(st(0, 0), ev(ST_MEM, 1, 0, 1, 0, 0, PC_INC, 0));
        end
        push(st(0, 1), ev(ST_MEM,    1, 0, 1, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_WB,     0, 0, 0, 0, 1, PC_INC, 1));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL load cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL load cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // Two stores; ctl_rwren is held high to show rf_we never follows it.
    task automatic test_store();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h4243, 1'b1, 1'b1, 1'b0, 1'b0);
        push(st(1, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_MEM,    1, 1, 1, 0, 1, PC_INC, 0));
        push(st(0, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_MEM,    1, 1, 1, 0, 1, PC_INC, 0));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL store cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL store cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // Jump+branch together resolves to jump; then a branch-only instruction.
    task automatic test_jcond();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h4EC5, 1'b0, 1'b0, 1'b1, 1'b1);
        push(st(1, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_WB,     0, 0, 0, 0, 1, PC_JMP, 0));
        set_ctl(16'h4EC5, 1'b0, 1'b0, 1'b0, 1'b1);
        push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_WB,     0, 0, 0, 0, 1, PC_BR,  0));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL jcond cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL jcond cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // run falls in EXEC: the instruction still completes, then IDLE.
    task automatic test_run_drop();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h5123, 1'b1, 1'b0, 1'b0, 1'b0);
        push(st(1, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_WB,     0, 0, 0, 0, 1, PC_INC, 1));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL run_drop cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL run_drop cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // 17 ALU instructions with random fetch stalls (below the limit): the
    // 4-bit retired counter wraps.
    task automatic test_back_to_back();
        logic [OW-1:0] e;
        int cyc;
        int d;
        logic last;
        set_ctl(16'h5123, 1'b1, 1'b0, 1'b0, 1'b0);
        push(st(1, 1), ev(ST_IDLE, 0, 0, 0, 0, 0, PC_INC, 0));
        for (int i = 0; i < 17; i++) begin
            last = (i == 16);
            d = $urandom_range(0, 2);
            for (int k = 0; k < d; k++) begin
                push(st(1, 0), ev(ST_FETCH, 1, 0, 0, 0, 0, PC_INC, 0));
            end
            push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
            push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
            push(st(1, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
            push(st(!last, 1), ev(ST_WB, 0, 0, 0, 0, 1, PC_INC, 1));
        end
        push(st(0, 0), ev(ST_IDLE, 0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL back_to_back cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL back_to_back cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // Reset pulsed while a store waits in MEM: no write strobe afterwards.
    task automatic test_reset_mid_store();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h4243, 1'b0, 1'b1, 1'b0, 1'b0);
        push(st(1, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_FETCH,  1, 0, 0, 1, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_DECODE, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_EXEC,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 0), ev(ST_MEM,    1, 1, 1, 0, 0, PC_INC, 0));
        push(st_rst(), ev(ST_MEM,    1, 1, 1, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 1), ev(ST_IDLE,   0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL reset_mid_store cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL reset_mid_store cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // mem_ready never arrives in FETCH: FAULT after WAIT_LIMIT+1 cycles,
    // held with all strobes low despite run/ready, cleared by reset.
    task automatic test_fault();
        logic [OW-1:0] e;
        int cyc;
        set_ctl(16'h5123, 1'b1, 1'b1, 1'b1, 1'b1);
        push(st(1, 0), ev(ST_IDLE, 0, 0, 0, 0, 0, PC_INC, 0));
        for (int i = 0; i < WAIT_LIMIT + 1; i++) begin
            push(st(1, 0), ev(ST_FETCH, 1, 0, 0, 0, 0, PC_INC, 0));
        end
        push(st(1, 1), ev(ST_FAULT, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(1, 1), ev(ST_FAULT, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st_rst(), ev(ST_FAULT, 0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 0), ev(ST_IDLE,  0, 0, 0, 0, 0, PC_INC, 0));
        push(st(0, 0), ev(ST_IDLE,  0, 0, 0, 0, 0, PC_INC, 0));
        cyc = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL fault cyc=%0d outputs got=%h exp=%h", cyc, obs_vec(), e);
            end
            n_checks++;
            if (retired !== exp_ret) begin
                n_errors++;
                $display("FAIL fault cyc=%0d retired got=%0d exp=%0d", cyc, retired, exp_ret);
            end
            if (!cur_stim[6]) exp_ret = '0;
            else if (e[5]) exp_ret = exp_ret + 1'b1;
            cyc++;
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

    // sequence + final report
    initial begin
        c_rw = 1'b0;
        c_dw = 1'b0;
        c_j  = 1'b0;
        c_b  = 1'b0;
        cur_stim = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jcond();
        test_run_drop();
        test_back_to_back();
        test_reset_mid_store();
        test_fault();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit processor.
- Steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB over a single shared single-port memory.
- Gates the combinational decoder's write enables (ctl_rwren, ctl_dwren) so register-file and memory writes happen only in their proper state.
- Drives PC update, IR load and memory address-source selection.

Parameters:
- WAIT_LIMIT, 15: max cycles waiting for mem_ready in FETCH or MEM before entering FAULT (1..255).
- RET_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  1 = execute continuously; sampled only at instruction boundaries.
- instr  in  16  IR contents; opcode = [15:12], mem_jmp = [7], st_ld = [6].
- ctl_rwren  in  1  register-write request from the instruction decoder.
- ctl_dwren  in  1  data-memory write request from the decoder.
- ctl_jmp  in  1  jump taken, from the decoder.
- ctl_branch  in  1  branch taken, from the decoder.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write strobe; valid only with mem_req.
- mem_addr_sel  out  1  0 = PC drives the address, 1 = register-file data address drives it.
- ir_load  out  1  IR captures memory read data this edge.
- pc_en  out  1  PC updates this edge.
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = jump target.
- rf_we  out  1  register-file write enable.
- state  out  3  current state encoding, for debug.
- busy  out  1  1 when state is neither IDLE nor FAULT.
- fault  out  1  memory timeout occurred; sticky.
- retired  out  RET_W  count of completed instructions; wraps modulo 2^RET_W.

Behaviour:
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, FAULT = 6.
- The state register, wait counter, retired counter and fault flag are registered. All strobes are combinational from state, mem_ready and the ctl_* inputs.
- Reset:
  - When rst_n = 0 at an edge: state = IDLE, wait counter = 0, retired = 0, fault = 0.
  - All strobes (mem_req, mem_we, ir_load, pc_en, rf_we) read 0 while in IDLE; pc_src = 00 and mem_addr_sel = 0.
  - Reset mid-access abandons the access; no write strobe is asserted in the cycle following reset.
- IDLE: go to FETCH if run = 1, else stay.
- FETCH:
  - Drives mem_req = 1, mem_addr_sel = 0, mem_we = 0.
  - On mem_ready: ir_load = 1, go to DECODE.
- DECODE: one cycle for the decoder to settle on the new IR; no strobes; go to EXEC.
- EXEC classifies the instruction:
  - Memory op is opcode = 4'b0100 with instr[7] = 0. If so, go to MEM.
  - Otherwise go to WB.
- MEM:
  - Drives mem_req = 1, mem_addr_sel = 1, mem_we = ctl_dwren.
  - On mem_ready for a store (instr[6] = 1): pc_en = 1, pc_src = 00, retire; next state is FETCH if run = 1, else IDLE.
  - On mem_ready for a load: go to WB.
- WB:
  - rf_we = ctl_rwren and pc_en = 1.
  - pc_src = 10 if ctl_jmp, else 01 if ctl_branch, else 00. ctl_jmp and ctl_branch both high resolves to jump.
  - Retire; next state is FETCH if run = 1, else IDLE.
- Retire: retired increments on every pc_en cycle. A count of all ones wraps to 0.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle in those states while mem_ready = 0.
  - When the counter equals WAIT_LIMIT with mem_ready still 0, go to FAULT.
  - mem_ready arriving in that same cycle takes priority: no fault.
- FAULT: fault = 1, all strobes 0, state held until reset. run is ignored.
- run deasserted mid-instruction: the instruction completes, then the block returns to IDLE.
- Latencies with zero-wait memory: non-memory instruction = 4 cycles, load = 5, store = 4.
- Write strobes (mem_we, rf_we) are never asserted in FETCH, DECODE, EXEC or FAULT.

Decomposition:
- Shared package: state encodings, pc_src codes (PC_INC, PC_BR, PC_JMP), opcode constant OP_MEM = 4'b0100, instr bit positions for mem_jmp and st_ld.
- One natural sub-module: seq_wait_timer, holding the wait counter and WAIT_LIMIT compare, with inputs clear/enable/ready and output timeout.
- The FSM, output decode and retire counter stay in multicycle_sequencer.

Test Plan:
- Reset then run = 1, instr = 16'h5123 (immediate ALU), ctl_rwren = 1, mem_ready always 1:
  - required: states 0→1→2→3→5→1.
  - required: ir_load in FETCH, rf_we = 1 and pc_en = 1 with pc_src = 00 in WB, retired = 1.
- Load, instr = 16'h4203, ctl_rwren = 1, mem_ready delayed 3 cycles in MEM:
  - required: mem_req = 1 and mem_addr_sel = 1 for 4 cycles, mem_we = 0.
  - required: WB asserts rf_we; total 8 cycles.
- Store, instr = 16'h4243, ctl_dwren = 1: required mem_we = 1 only in MEM; pc_en in MEM; rf_we never asserted; next state FETCH.
- Jcond, instr = 16'h4EC5, ctl_jmp = 1 and ctl_branch = 1 together: required WB with pc_src = 10 and rf_we = 0.
- WAIT_LIMIT = 3, mem_ready held 0 in FETCH:
  - required: FAULT after 4 FETCH cycles, fault = 1, all strobes 0.
  - required: rst_n low for 1 cycle returns to IDLE with retired = 0.
- run dropped during EXEC, and separately rst_n pulsed during MEM of a store:
  - required: the first instruction completes and the block goes to IDLE.
  - required: the reset case goes to IDLE with no mem_we pulse after reset.
